// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum
//   Folds a valid/ready stream of WIDTH-bit words into a single XOR checksum
//   per frame. It also reports a parity bit, the frame length (saturating at
//   MAX_LEN) and an overlength flag. One result is presented per frame.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   in_valid/in_ready         word handshake from the source
//   in_data, in_last          word to fold, end-of-frame marker
//   out_valid/out_ready       result handshake to the sink
//   out_sum                   XOR of every word in the frame
//   out_parity                ^out_sum, inverted when ODD_PARITY != 0
//   out_len                   words in the frame, saturating at MAX_LEN
//   out_err                   frame was longer than MAX_LEN words
//
// State table
//   IDLE  | no frame open, waiting for the first word
//   ACCUM | frame open, at least one word folded in
//   HOLD  | result presented, input stalled until the sink takes it

module xor_frame_checksum #(
    parameter int WIDTH      = 8,
    parameter int MAX_LEN    = 16,
    parameter int ODD_PARITY = 0,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err
);

    localparam logic             PAR_INV = (ODD_PARITY != 0);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic             err, err_nxt;
    logic             accept;
    logic             load_res;

    // in_ready depends only on the registered state, so the sink's out_ready
    // never reaches back to the source combinationally.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            len        <= '0;
            err        <= 1'b0;
            out_sum    <= '0;
            out_len    <= '0;
            out_err    <= 1'b0;
            out_parity <= PAR_INV;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            len   <= len_nxt;
            err   <= err_nxt;
            // Result registers keep their values after the transfer; only
            // out_valid drops.
            if (load_res) begin
                out_sum    <= acc_nxt;
                out_len    <= len_nxt;
                out_err    <= err_nxt;
                out_parity <= (^acc_nxt) ^ PAR_INV;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        len_nxt   = len;
        err_nxt   = err;
        load_res  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = in_data;
                    len_nxt   = LEN_ONE;
                    err_nxt   = 1'b0;
                    load_res  = in_last;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = acc ^ in_data;
                    // The flag goes up on word MAX_LEN+1; the count stays
                    // pinned at MAX_LEN from then on.
                    if (len < LEN_MAX) begin
                        len_nxt = len + LEN_ONE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    load_res  = in_last;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xor_frame_checksum.sv
module tb_xor_frame_checksum;

    localparam int WIDTH   = 8;
    localparam int MAX_A   = 4;
    localparam int MAX_B   = 16;
    localparam int LEN_A_W = $clog2(MAX_A + 1);
    localparam int LEN_B_W = $clog2(MAX_B + 1);

    typedef struct {
        logic [WIDTH-1:0] sum;
        int               len;
        logic             err;
        logic             par;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b0;

    logic               in_ready_a, out_valid_a, out_parity_a, out_err_a;
    logic [WIDTH-1:0]   out_sum_a;
    logic [LEN_A_W-1:0] out_len_a;
    logic               in_ready_b, out_valid_b, out_parity_b, out_err_b;
    logic [WIDTH-1:0]   out_sum_b;
    logic [LEN_B_W-1:0] out_len_b;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] frame_q[$];
    exp_t             sb_a[$];
    exp_t             sb_b[$];

    always #5 clk = ~clk;

    // Short frame limit, even parity.
    xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_A), .ODD_PARITY(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_parity(out_parity_a), .out_len(out_len_a), .out_err(out_err_a)
    );

    // Default frame limit, odd parity.
    xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_B), .ODD_PARITY(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_parity(out_parity_b), .out_len(out_len_b), .out_err(out_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int max_len, input bit odd);
        exp_t e;
        e.sum = '0;
        e.len = 0;
        e.err = 1'b0;
        foreach (frame_q[i]) begin
            e.sum = e.sum ^ frame_q[i];
            if (e.len < max_len) e.len++;
            else e.err = 1'b1;
        end
        e.par = (^e.sum) ^ odd;
        return e;
    endfunction

    task automatic push_expected();
        sb_a.push_back(model(MAX_A, 1'b0));
        sb_b.push_back(model(MAX_B, 1'b1));
    endtask

    task automatic compare_result(input string tag);
        exp_t ea, eb;
        if (sb_a.size() == 0 || sb_b.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            chk({tag, "_valid_a"},  32'(out_valid_a),  32'd1);
            chk({tag, "_valid_b"},  32'(out_valid_b),  32'd1);
            chk({tag, "_sum_a"},    32'(out_sum_a),    32'(ea.sum));
            chk({tag, "_len_a"},    32'(out_len_a),    32'(ea.len));
            chk({tag, "_err_a"},    32'(out_err_a),    32'(ea.err));
            chk({tag, "_par_a"},    32'(out_parity_a), 32'(ea.par));
            chk({tag, "_sum_b"},    32'(out_sum_b),    32'(eb.sum));
            chk({tag, "_len_b"},    32'(out_len_b),    32'(eb.len));
            chk({tag, "_err_b"},    32'(out_err_b),    32'(eb.err));
            chk({tag, "_par_b"},    32'(out_parity_b), 32'(eb.par));
        end
    endtask

    // Drives frame_q as one frame, then checks the result the cycle after the
    // last word is accepted.
    task automatic send_frame(input string tag, input bit gaps);
        int budget;
        push_expected();
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 8'hEE;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            budget   = 20;
            while (!(in_ready_a && in_ready_b) && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        compare_result(tag);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 32'(out_valid_a | out_valid_b), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready_a & in_ready_b), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("rst_valid",  32'(out_valid_a), 32'd0);
        chk("rst_ready",  32'(in_ready_a),  32'd1);
        chk("rst_sum",    32'(out_sum_a),   32'd0);
        chk("rst_len",    32'(out_len_a),   32'd0);
        chk("rst_err",    32'(out_err_a),   32'd0);
        chk("rst_par_a",  32'(out_parity_a), 32'd0);
        chk("rst_par_b",  32'(out_parity_b), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-word frame with the sink already ready.
        out_ready = 1'b1;
        frame_q = '{8'hA5};
        send_frame("single", 1'b0);
        @(negedge clk);
        chk("single_drop_valid", 32'(out_valid_a | out_valid_b), 32'd0);
        chk("single_keep_sum",   32'(out_sum_a), 32'hA5);
        out_ready = 1'b0;

        frame_q = '{8'h0F, 8'hF0, 8'h3C};
        send_frame("multi", 1'b0);
        release_result("multi");

        // Backpressure: result held five cycles while the source keeps offering.
        frame_q = '{8'h01, 8'h02};
        send_frame("bp", 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b1;
        frame_q  = '{8'h5A};
        push_expected();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_ready_a | in_ready_b), 32'd0);
            chk("bp_valid",     32'(out_valid_a & out_valid_b), 32'd1);
            chk("bp_sum_a",     32'(out_sum_a), 32'h03);
            chk("bp_len_b",     32'(out_len_b), 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_xfer_valid", 32'(out_valid_a | out_valid_b), 32'd0);
        chk("bp_xfer_ready", 32'(in_ready_a & in_ready_b), 32'd1);
        chk("bp_xfer_keep",  32'(out_sum_b), 32'h03);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        compare_result("bp_next");
        release_result("bp_next");

        frame_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        send_frame("over6", 1'b0);
        release_result("over6");

        frame_q = '{8'h12, 8'h34};
        send_frame("after_over", 1'b0);
        release_result("after_over");

        // Exactly one word past the limit of the short instance.
        frame_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        send_frame("over5", 1'b0);
        release_result("over5");

        // Exactly at the limit, with idle gaps and stray in_last between words.
        frame_q = '{8'h11, 8'h22, 8'h44, 8'h88};
        send_frame("gapped", 1'b1);
        release_result("gapped");

        // Reset in the middle of a frame after three words.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(i);
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid_a | out_valid_b), 32'd0);
        chk("midrst_ready", 32'(in_ready_a & in_ready_b), 32'd1);
        chk("midrst_sum",   32'(out_sum_a | out_sum_b), 32'd0);
        chk("midrst_len",   32'(out_len_a), 32'd0);
        chk("midrst_err",   32'(out_err_a), 32'd0);
        chk("midrst_par_b", 32'(out_parity_b), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        frame_q = '{8'h12, 8'h34};
        send_frame("post_rst", 1'b0);
        release_result("post_rst");

        chk("sb_drained", 32'(sb_a.size() + sb_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_frame_checksum.md
Name: xor_frame_checksum

Overview:
- Streaming, parametrised successor of the two-input XOR gate.
- Folds an arbitrary-length frame of WIDTH-bit words into one XOR checksum word, plus a parity bit and the frame length.
- Valid/ready on both sides. Sits between a word-stream source and a checker or framer that consumes one result per frame.

Parameters:
- WIDTH, 8, data and checksum width in bits (>=1).
- MAX_LEN, 16, maximum legal frame length in words (>=1); longer frames are flagged.
- ODD_PARITY, 0, 0: out_parity = XOR of all out_sum bits; 1: that value inverted.
- LEN_W, $clog2(MAX_LEN+1), length counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  source has a word
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  word to fold
- in_last  input  1  word is the final word of the frame
- out_valid  output  1  frame result available
- out_ready  input  1  sink takes the result
- out_sum  output  WIDTH  XOR of all words in the frame
- out_parity  output  1  parity of out_sum per ODD_PARITY
- out_len  output  LEN_W  words in the frame, saturating at MAX_LEN
- out_err  output  1  frame exceeded MAX_LEN words

Behaviour:
- Accept = in_valid & in_ready, sampled on rising clk. Result transfer = out_valid & out_ready.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, at least one word taken.
  - HOLD: result presented.
- Reset (async assert, any time, including mid-frame or in HOLD):
  - state=IDLE; accumulator, length and err cleared.
  - out_valid=0, out_sum=0, out_parity=ODD_PARITY, out_len=0, out_err=0.
  - A partial frame is discarded. Deassertion is taken synchronously by the design.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is a registered-state decode with no combinational path from out_ready.
- IDLE, accept:
  - acc<=in_data; len<=1; err<=0.
  - If in_last: go to HOLD (single-word frame). Otherwise go to ACCUM.
- ACCUM, accept:
  - acc<=acc^in_data.
  - len<=len+1 if len<MAX_LEN, else len holds at MAX_LEN and err<=1.
  - If in_last: go to HOLD. Otherwise stay in ACCUM.
  - err is set when word MAX_LEN+1 is accepted, not before.
- Result registers:
  - On entering HOLD: out_sum, out_len and out_err load the final (post-update) values; out_parity = ^out_sum ^ ODD_PARITY.
  - out_valid rises the cycle after the last word is accepted (latency 1).
- HOLD:
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - On transfer: out_valid<=0 next cycle and state goes to IDLE. out_sum, out_len, out_err and out_parity keep their last values.
  - No input is accepted in the transfer cycle. The earliest next accept is the cycle after.
- No-valid cycles (in_valid=0) in IDLE/ACCUM change nothing.
- in_last with in_valid=0 is ignored.
- WIDTH=1 degenerates to a serial parity accumulator. out_sum equals the raw parity, and out_parity follows the same ODD_PARITY rule.

Test Plan:
- Reset values: assert rst mid-ACCUM after 3 words -> out_valid=0, in_ready=1, out_sum=0, out_len=0, out_err=0 immediately. A new frame after reset yields only its own words.
- Single-word frame: WIDTH=8, word 0xA5 with in_last, out_ready=1 -> out_valid one cycle later, out_sum=0xA5, out_len=1, out_parity=0, out_err=0.
- Multi-word frame: words 0x0F, 0xF0, 0x3C (last) -> out_sum=0xC3, out_len=3, out_parity=0. With ODD_PARITY=1 -> out_parity=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 and outputs stable throughout. Release out_ready -> transfer, then the next frame's first word is accepted the following cycle.
- Overlength: MAX_LEN=4, frame of 6 words each 0x01 -> out_len=4, out_err=1, out_sum=0x00. A following 2-word frame 0x12, 0x34 -> out_err=0, out_len=2, out_sum=0x26.
- Gapped input: 4-word frame 0x11, 0x22, 0x44, 0x88 with in_valid low between words and a stray in_last while in_valid=0 -> out_sum=0xFF, out_len=4, out_parity=0.
